systolic_pe_v2: RTL

SYSTOLIC_PE_V2 -- requirements
Module: systolic_pe_v2

---
 rtl/matmul_pkg.sv | 31 +++
 rtl/pe_mac_sat.sv | 51 +++++
 rtl/systolic_pe_v2.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// ----------------------------------------------------------------------------
// matmul_pkg
// Shared types and helpers for the systolic matrix-multiply processing element.
//   pe_state_t : PE control states (IDLE / COMPUTE / DRAIN)
//   pe_mode_t  : dataflow mode latched at start (OS = output-stationary,
//                WS = weight-stationary)
//   acc_max / acc_min : signed saturation limits for a given accumulator width,
//                returned as 64-bit signed values so callers can size-cast them.
// ----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } pe_state_t;

    typedef enum logic {
        OS = 1'b0,
        WS = 1'b1
    } pe_mode_t;

    function automatic logic signed [63:0] acc_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage : matmul_pkg

// File: rtl/pe_mac_sat.sv
// ----------------------------------------------------------------------------
// pe_mac_sat
// Combinational saturating multiply-add: o_sum = sat(i_addend + i_a * i_b).
// The product is kept at full 2*DATA_WIDTH precision and the sum is formed one
// bit wider than the widest operand, so the clamp decision is exact.
// Ports:
//   i_a, i_b   : signed DATA_WIDTH operands
//   i_addend   : signed ACC_WIDTH addend (accumulator or incoming partial sum)
//   o_sum      : clamped signed ACC_WIDTH result
//   o_ovf      : high when the result was clamped to max or min
// ----------------------------------------------------------------------------
module pe_mac_sat
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    input  logic signed [ACC_WIDTH-1:0]  i_addend,
    output logic signed [ACC_WIDTH-1:0]  o_sum,
    output logic                         o_ovf
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    // With the default widths this is ACC_WIDTH+1; it only grows if the
    // product is wider than the accumulator.
    localparam int SUM_W  = ((PROD_W > ACC_WIDTH) ? PROD_W : ACC_WIDTH) + 1;

    localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'(acc_max(ACC_WIDTH));
    localparam logic signed [SUM_W-1:0] C_MIN = SUM_W'(acc_min(ACC_WIDTH));

    logic signed [PROD_W-1:0] w_prod;
    logic signed [SUM_W-1:0]  w_sum;

    assign w_prod = i_a * i_b;
    assign w_sum  = $signed(SUM_W'(w_prod)) + $signed(SUM_W'(i_addend));

    always_comb begin
        o_sum = w_sum[ACC_WIDTH-1:0];
        o_ovf = 1'b0;
        if (w_sum > C_MAX) begin
            o_sum = C_MAX[ACC_WIDTH-1:0];
            o_ovf = 1'b1;
        end else if (w_sum < C_MIN) begin
            o_sum = C_MIN[ACC_WIDTH-1:0];
            o_ovf = 1'b1;
        end
    end

endmodule : pe_mac_sat

// File: rtl/systolic_pe_v2.sv
// ----------------------------------------------------------------------------
// systolic_pe_v2
// Processing element for a systolic matrix-multiply array supporting
// output-stationary (OS) and weight-stationary (WS) dataflow.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; WS weight may be preloaded via w_load
//   COMPUTE | OS: accumulate a*b into acc; WS: psum_out = psum_in + w*b
//   DRAIN   | OS only: forward upstream drain chain until it goes invalid
//
// Ports:
//   clk, rst (sync, active-high), en (global stall, low = hold everything)
//   start/mode    : begin operation, mode sampled with start (0=OS, 1=WS)
//   w_load        : latch a_in into weight register (IDLE only)
//   drain         : end compute phase (COMPUTE only)
//   a_in/a_valid_in, b_in/b_valid_in   : north / west operands
//   a_out/a_valid_out, b_out/b_valid_out : registered pass-through
//   psum_in, psum_out/psum_valid_out   : WS partial-sum chain
//   drain_in/drain_valid_in, drain_out/drain_valid_out : OS drain chain
//   busy (state != IDLE), sat_flag (sticky until next start or rst)
// ----------------------------------------------------------------------------
module systolic_pe_v2
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         w_load,
    input  logic                         drain,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic                         a_valid_in,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    input  logic                         b_valid_in,
    output logic signed [DATA_WIDTH-1:0] a_out,
    output logic                         a_valid_out,
    output logic signed [DATA_WIDTH-1:0] b_out,
    output logic                         b_valid_out,
    input  logic signed [ACC_WIDTH-1:0]  psum_in,
    output logic signed [ACC_WIDTH-1:0]  psum_out,
    output logic                         psum_valid_out,
    input  logic signed [ACC_WIDTH-1:0]  drain_in,
    input  logic                         drain_valid_in,
    output logic signed [ACC_WIDTH-1:0]  drain_out,
    output logic                         drain_valid_out,
    output logic                         busy,
    output logic                         sat_flag
);

    pe_state_t r_state;
    pe_state_t w_state_nxt;
    pe_mode_t  r_mode;

    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [DATA_WIDTH-1:0] r_w;
    logic signed [DATA_WIDTH-1:0] r_a_out;
    logic signed [DATA_WIDTH-1:0] r_b_out;
    logic                         r_a_valid_out;
    logic                         r_b_valid_out;
    logic signed [ACC_WIDTH-1:0]  r_psum_out;
    logic                         r_psum_valid_out;
    logic signed [ACC_WIDTH-1:0]  r_drain_out;
    logic                         r_drain_valid_out;
    logic                         r_sat;

    logic signed [DATA_WIDTH-1:0] w_mac_a;
    logic signed [ACC_WIDTH-1:0]  w_mac_addend;
    logic signed [ACC_WIDTH-1:0]  w_mac_sum;
    logic                         w_mac_ovf;
    logic                         w_os_fire;
    logic                         w_ws_fire;
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt;

    // One MAC serves both dataflows; the latched mode picks the operands.
    assign w_mac_a      = (r_mode == WS) ? r_w : a_in;
    assign w_mac_addend = (r_mode == WS) ? psum_in : r_acc;

    pe_mac_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .i_a      (w_mac_a),
        .i_b      (b_in),
        .i_addend (w_mac_addend),
        .o_sum    (w_mac_sum),
        .o_ovf    (w_mac_ovf)
    );

    assign w_os_fire = (r_state == COMPUTE) && (r_mode == OS) && a_valid_in && b_valid_in;
    assign w_ws_fire = (r_state == COMPUTE) && (r_mode == WS) && b_valid_in;

    // Drain captures the accumulator including a MAC landing on the same edge.
    assign w_acc_nxt = w_os_fire ? w_mac_sum : r_acc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                if (drain) begin
                    w_state_nxt = (r_mode == OS) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!drain_valid_in) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_mode            <= OS;
            r_acc             <= '0;
            r_w               <= '0;
            r_a_out           <= '0;
            r_b_out           <= '0;
            r_a_valid_out     <= 1'b0;
            r_b_valid_out     <= 1'b0;
            r_psum_out        <= '0;
            r_psum_valid_out  <= 1'b0;
            r_drain_out       <= '0;
            r_drain_valid_out <= 1'b0;
            r_sat             <= 1'b0;
        end else if (en) begin
            r_state       <= w_state_nxt;
            r_a_out       <= a_in;
            r_b_out       <= b_in;
            r_a_valid_out <= a_valid_in;
            r_b_valid_out <= b_valid_in;

            // Valid outputs are single-cycle strobes unless re-asserted below.
            r_psum_valid_out  <= 1'b0;
            r_drain_valid_out <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_w <= a_in;
                    end
                    if (start) begin
                        r_mode <= pe_mode_t'(mode);
                        r_acc  <= '0;
                        r_sat  <= 1'b0;
                    end
                end
                COMPUTE: begin
                    if (w_os_fire) begin
                        r_acc <= w_mac_sum;
                    end
                    if ((w_os_fire || w_ws_fire) && w_mac_ovf) begin
                        r_sat <= 1'b1;
                    end
                    if (w_ws_fire) begin
                        r_psum_out       <= w_mac_sum;
                        r_psum_valid_out <= 1'b1;
                    end
                    if (drain && (r_mode == OS)) begin
                        r_drain_out       <= w_acc_nxt;
                        r_drain_valid_out <= 1'b1;
                    end
                end
                DRAIN: begin
                    r_drain_out       <= drain_in;
                    r_drain_valid_out <= drain_valid_in;
                end
                default: ;
            endcase
        end
    end

    assign a_out           = r_a_out;
    assign a_valid_out     = r_a_valid_out;
    assign b_out           = r_b_out;
    assign b_valid_out     = r_b_valid_out;
    assign psum_out        = r_psum_out;
    assign psum_valid_out  = r_psum_valid_out;
    assign drain_out       = r_drain_out;
    assign drain_valid_out = r_drain_valid_out;
    assign busy            = (r_state != IDLE);
    assign sat_flag        = r_sat;

endmodule : systolic_pe_v2
